prbs32_checker: RTL and testbench

Serial receive-side checker for the 32-bit m-sequence generator. It accepts one bit per qualified clock and self-synchronizes to the sequence. Once locked, it free-runs a local copy of the sequence and counts bit errors. It sits at the far end of a link or loopback fed by the generator's MSB output, and provides lock status and BER counters to the host.

---
 rtl/prbs_pkg.sv | 23 ++
 rtl/prbs32_history.sv | 27 ++
 rtl/prbs32_checker.sv | 118 +++++++++++
 tb/tb_prbs32_checker.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/prbs_pkg.sv
// Shared constants and types for the 32-bit PRBS checker.
package prbs_pkg;

  localparam int unsigned SEQ_LEN = 32;

  // Output-recurrence taps: b[n] = b[n-1]^b[n-3]^b[n-7]^b[n-8]^b[n-32]
  localparam int unsigned TAP_A = 1;
  localparam int unsigned TAP_B = 3;
  localparam int unsigned TAP_C = 7;
  localparam int unsigned TAP_D = 8;
  localparam int unsigned TAP_E = 32;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } prbs_state_t;

  // h[k] (bit k samples ago) lives at index k-1
  function automatic logic predict(input logic [SEQ_LEN-1:0] h);
    return h[TAP_A-1] ^ h[TAP_B-1] ^ h[TAP_C-1] ^ h[TAP_D-1] ^ h[TAP_E-1];
  endfunction

endpackage

// File: rtl/prbs32_history.sv
// Received-bit history with load select, next-bit prediction and lock-up detect.
module prbs32_history
  import prbs_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic shift_en,
  input  logic sel_pred,
  input  logic din,
  output logic pred,
  output logic hzero
);

  logic [SEQ_LEN-1:0] hist;

  assign pred  = predict(hist);
  assign hzero = (hist == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= '0;
    end else if (shift_en) begin
      hist <= {hist[SEQ_LEN-2:0], (sel_pred ? pred : din)};
    end
  end

endmodule

// File: rtl/prbs32_checker.sv
// Self-synchronising PRBS32 receive checker: lock FSM, loss window and BER counters.
module prbs32_checker
  import prbs_pkg::*;
#(
  parameter int unsigned LOCK_CNT = 64,
  parameter int unsigned LOSS_WIN = 64,
  parameter int unsigned LOSS_ERR = 8,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din_valid,
  input  logic             din,
  input  logic             clr,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] bit_cnt
);

  localparam int unsigned FILL_W = $clog2(SEQ_LEN + 1);
  localparam int unsigned RUN_W  = $clog2(LOCK_CNT + 1);
  localparam int unsigned WIN_W  = $clog2(LOSS_WIN + 1);
  localparam int unsigned WERR_W = $clog2(LOSS_ERR + 1);

  prbs_state_t       state, state_d;
  logic [FILL_W-1:0] fill;
  logic [RUN_W-1:0]  run;
  logic [WIN_W-1:0]  wcnt;
  logic [WERR_W-1:0] werr, werr_inc;
  logic              pred, hzero, filled, miss;
  logic              lock_hit, loss_hit, chk_bit, chk_err;

  prbs32_history u_hist (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (din_valid),
    .sel_pred (state == LOCKED),
    .din      (din),
    .pred     (pred),
    .hzero    (hzero)
  );

  assign filled   = (fill == FILL_W'(SEQ_LEN));
  assign miss     = (din != pred);
  assign werr_inc = werr + WERR_W'(miss);
  assign chk_bit  = din_valid && (state == LOCKED);
  assign chk_err  = chk_bit && miss;
  assign locked   = (state == LOCKED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SEARCH;
    else        state <= state_d;
  end

  always_comb begin
    state_d  = state;
    lock_hit = 1'b0;
    loss_hit = 1'b0;
    if (din_valid) begin
      unique case (state)
        SEARCH: if (filled && !miss && !hzero && run == RUN_W'(LOCK_CNT - 1)) begin
          state_d  = LOCKED;
          lock_hit = 1'b1;
        end
        LOCKED: if (miss && werr_inc == WERR_W'(LOSS_ERR)) begin
          state_d  = SEARCH;
          loss_hit = 1'b1;
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  // Fill, run and window bookkeeping; window counters are only live in LOCKED
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill <= '0;
      run  <= '0;
      wcnt <= '0;
      werr <= '0;
    end else if (din_valid) begin
      if (state == SEARCH) begin
        if (!filled)                    fill <= fill + FILL_W'(1);
        else if (lock_hit)              run  <= '0;
        else if (!miss && !hzero)       run  <= run + RUN_W'(1);
        else                            run  <= '0;
      end else if (loss_hit) begin
        fill <= '0;
        run  <= '0;
        wcnt <= '0;
        werr <= '0;
      end else if (wcnt == WIN_W'(LOSS_WIN - 1)) begin
        wcnt <= '0;
        werr <= '0;
      end else begin
        wcnt <= wcnt + WIN_W'(1);
        werr <= werr_inc;
      end
    end
  end

  // A clear coincident with a counted event loads 1 rather than 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err     <= 1'b0;
      err_cnt <= '0;
      bit_cnt <= '0;
    end else begin
      err <= chk_err;
      if (clr)                          err_cnt <= chk_err ? CNT_W'(1) : '0;
      else if (chk_err && err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
      if (clr)                          bit_cnt <= chk_bit ? CNT_W'(1) : '0;
      else if (chk_bit && bit_cnt != '1) bit_cnt <= bit_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_prbs32_checker.sv
// Directed self-checking bench for prbs32_checker (default and 4-bit-counter instances).
module tb_prbs32_checker;

  logic        clk = 1'b0;
  logic        rst_n, din_valid, din, clr;
  logic        locked, err, locked2, err2;
  logic [31:0] err_cnt, bit_cnt;
  logic [3:0]  err_cnt2, bit_cnt2;

  int          n_chk = 0;
  int          n_pass = 0;
  logic [31:0] gh;
  int          gn;

  always #5 clk = ~clk;

  prbs32_checker dut (
    .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din), .clr(clr),
    .locked(locked), .err(err), .err_cnt(err_cnt), .bit_cnt(bit_cnt)
  );

  prbs32_checker #(.LOCK_CNT(64), .LOSS_WIN(64), .LOSS_ERR(100), .CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din), .clr(clr),
    .locked(locked2), .err(err2), .err_cnt(err_cnt2), .bit_cnt(bit_cnt2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step(input logic v, input logic d, input logic c);
    @(negedge clk);
    din_valid = v;
    din       = d;
    clr       = c;
    @(posedge clk);
    #1;
  endtask

  // Generator model: b[0..30]=0, b[31]=1, then the output recurrence
  task automatic send(input logic flip, input logic c);
    logic b;
    if (gn < 31)       b = 1'b0;
    else if (gn == 31) b = 1'b1;
    else               b = gh[0] ^ gh[2] ^ gh[6] ^ gh[7] ^ gh[31];
    gh = {gh[30:0], b};
    gn++;
    step(1'b1, b ^ flip, c);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; din_valid = 1'b0; din = 1'b0; clr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    gh = '0;
    gn = 0;
  endtask

  initial begin
    int errs, lk, hi, lost;
    logic [31:0] prev;

    do_reset();
    check("rst_locked", 32'(locked), 0);
    check("rst_err", 32'(err), 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_bit_cnt", bit_cnt, 0);

    // Clean lock: 32 fill + 64 matches
    for (int i = 0; i < 95; i++) send(1'b0, 1'b0);
    check("clean_pre_lock", 32'(locked), 0);
    send(1'b0, 1'b0);
    check("clean_lock_96", 32'(locked), 1);
    errs = 0;
    for (int i = 0; i < 10000; i++) begin
      send(1'b0, 1'b0);
      errs += int'(err);
    end
    check("clean_err_pulses", errs, 0);
    check("clean_err_cnt", err_cnt, 0);
    check("clean_bit_cnt", bit_cnt, 10000);
    lk = 10000;

    // Single error
    step(1'b0, 1'b0, 1'b1);
    check("clr_idle_bit_cnt", bit_cnt, 0);
    send(1'b1, 1'b0);
    check("single_err_pulse", 32'(err), 1);
    check("single_err_cnt", err_cnt, 1);
    send(1'b0, 1'b0);
    check("single_err_drop", 32'(err), 0);
    check("single_locked", 32'(locked), 1);
    check("single_bit_cnt", bit_cnt, 2);
    lk += 2;

    // Align to a fresh window, then an 8-bit burst
    for (int i = 0; i < 64; i++) begin send(1'b0, 1'b0); lk++; end
    while (lk % 64 != 0) begin send(1'b0, 1'b0); lk++; end
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) send(1'b1, 1'b0);
    check("burst7_locked", 32'(locked), 1);
    check("burst7_err_cnt", err_cnt, 7);
    send(1'b1, 1'b0);
    check("burst8_unlocked", 32'(locked), 0);
    check("burst8_err", 32'(err), 1);
    check("burst8_err_cnt", err_cnt, 8);
    for (int i = 0; i < 95; i++) send(1'b0, 1'b0);
    check("relock_pre", 32'(locked), 0);
    send(1'b0, 1'b0);
    check("relock_96", 32'(locked), 1);
    check("relock_err_cnt", err_cnt, 8);

    // Stuck-at-zero while locked
    prev = err_cnt;
    lost = 0;
    for (int i = 0; i < 64 && lost == 0; i++) begin
      step(1'b1, 1'b0, 1'b0);
      if (!locked) lost = 1;
    end
    check("stuck_lose_lock", lost, 1);
    check("stuck_err_grew", 32'(err_cnt > prev), 1);

    // Stuck-at-zero from reset
    do_reset();
    hi = 0;
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 1'b0, 1'b0);
      hi += int'(locked);
    end
    check("stuck_never_lock", hi, 0);

    // Gapped valid: same lock point and counts
    do_reset();
    for (int i = 0; i < 95; i++) begin
      send(1'b0, 1'b0);
      step(1'b0, 1'($urandom_range(1)), 1'b0);
    end
    check("gap_pre_lock", 32'(locked), 0);
    send(1'b0, 1'b0);
    check("gap_lock_96", 32'(locked), 1);
    errs = 0;
    for (int i = 0; i < 10000; i++) begin
      step(1'b0, 1'($urandom_range(1)), 1'b0);
      errs += int'(err);
      send(1'b0, 1'b0);
      errs += int'(err);
    end
    check("gap_err_pulses", errs, 0);
    check("gap_err_cnt", err_cnt, 0);
    check("gap_bit_cnt", bit_cnt, 10000);
    send(1'b1, 1'b1);
    check("clr_err_err_cnt", err_cnt, 1);
    check("clr_err_bit_cnt", bit_cnt, 1);

    // Asynchronous reset mid-lock, with err high
    send(1'b1, 1'b0);
    check("pre_rst_err", 32'(err), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_locked", 32'(locked), 0);
    check("async_rst_err", 32'(err), 0);
    check("async_rst_err_cnt", err_cnt, 0);
    check("async_rst_bit_cnt", bit_cnt, 0);

    // Saturation on the 4-bit instance (window disabled)
    do_reset();
    for (int i = 0; i < 96; i++) send(1'b0, 1'b0);
    check("sat_locked", 32'(locked2), 1);
    for (int i = 0; i < 20; i++) send(1'b1, 1'b0);
    check("sat_still_locked", 32'(locked2), 1);
    check("sat_err_cnt", 32'(err_cnt2), 15);
    check("sat_bit_cnt", 32'(bit_cnt2), 15);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
